// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared encodings and constants for the display channel
//               adapter: colour modes, luma weights and 2x2 Bayer table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    // Colour mode requests, sampled on the frame-start pixel
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_GREY   = 2'd1,
        MODE_BGR    = 2'd2,
        MODE_BLACK  = 2'd3
    } disp_mode_e;

    // Luma approximation Y = (2r + 5g + b) >> 3; weights sum to 8, so the
    // result never exceeds the input channel maximum.
    localparam int LUMA_WR    = 2;
    localparam int LUMA_WG    = 5;
    localparam int LUMA_WB    = 1;
    localparam int LUMA_SHIFT = 3;

    // 2x2 ordered-dither table indexed by {iy, ix}:
    // (0,0)->0, (1,0)->2, (0,1)->3, (1,1)->1
    localparam logic [7:0] BAYER_LUT = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] bayer_value(input logic ix, input logic iy);
        logic [7:0] lut;
        lut = BAYER_LUT;
        return lut[{iy, ix, 1'b0} +: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/disp_chan_conv.sv
// ============================================================================
// Module      : disp_chan_conv
// Description : Combinational single-channel colour depth converter.
//               Widening replicates the input bits MSB-first; narrowing
//               truncates, or applies a 2x2 ordered dither first when the
//               DISP_ADAPT_DITHER_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_chan_conv #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic [BPC_IN-1:0]  c_i,
`ifdef DISP_ADAPT_DITHER_EN
    input  logic [1:0]         bayer_i,
`endif
    output logic [BPC_OUT-1:0] c_o
);

    if (BPC_OUT == BPC_IN) begin : g_pass
        assign c_o = c_i;
    end else if (BPC_OUT > BPC_IN) begin : g_widen
        // Repeat the input pattern from the MSB down until the output is full
        always_comb begin
            c_o = '0;
            for (int i = 0; i < BPC_OUT; i++) begin
                c_o[BPC_OUT-1-i] = c_i[BPC_IN-1-(i % BPC_IN)];
            end
        end
    end else begin : g_narrow
        localparam int DROP = BPC_IN - BPC_OUT;
`ifdef DISP_ADAPT_DITHER_EN
        logic [BPC_IN:0]   thr;
        logic [BPC_IN:0]   sum;
        logic [BPC_IN-1:0] sat;

        // Threshold spans the dropped bits; a single dropped bit can only
        // take the top bit of the Bayer value.
        if (DROP >= 2) begin : g_thr_wide
            assign thr = (BPC_IN+1)'(bayer_i) << (DROP - 2);
        end else begin : g_thr_one
            assign thr = (BPC_IN+1)'(bayer_i[1]);
        end

        assign sum = {1'b0, c_i} + thr;
        assign sat = sum[BPC_IN] ? {BPC_IN{1'b1}} : sum[BPC_IN-1:0];
        assign c_o = sat[BPC_IN-1 -: BPC_OUT];
`else
        assign c_o = c_i[BPC_IN-1 -: BPC_OUT];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/disp_chan_adapt.sv
// ============================================================================
// Module      : disp_chan_adapt
// Description : Registered display output stage. Stage 1 applies the
//               frame-synchronous colour mode, stage 2 adapts channel depth
//               and blanks outside the active area, stages 3..PIPE delay.
//               Position and sync travel alongside the colour unchanged.
//               Optional macro DISP_ADAPT_DITHER_EN enables ordered dither
//               when narrowing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_chan_adapt
    import disp_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int CORDW   = 16,
    parameter int PIPE    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode_in,
    input  logic [CORDW-1:0]   in_x,
    input  logic [CORDW-1:0]   in_y,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    input  logic               in_frame,
    input  logic [BPC_IN-1:0]  in_r,
    input  logic [BPC_IN-1:0]  in_g,
    input  logic [BPC_IN-1:0]  in_b,
    output logic [CORDW-1:0]   out_x,
    output logic [CORDW-1:0]   out_y,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic               out_frame,
    output logic [BPC_OUT-1:0] out_r,
    output logic [BPC_OUT-1:0] out_g,
    output logic [BPC_OUT-1:0] out_b
);

    localparam int SW = 2*CORDW + 4 + 3*BPC_OUT;

    // ---------------- mode latch ----------------
    // The frame-start pixel already uses the newly requested mode
    disp_mode_e mode_q, mode_d;
    assign mode_d = in_frame ? disp_mode_e'(mode_in) : mode_q;

    // Hold the colour mode for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= MODE_NORMAL;
        else        mode_q <= mode_d;
    end

    // ---------------- stage 1: mode transform ----------------
    logic [BPC_IN+2:0] luma_sum;
    logic [BPC_IN-1:0] luma;
    logic [BPC_IN-1:0] r1_d, g1_d, b1_d;
    logic [BPC_IN-1:0] r1_q, g1_q, b1_q;
    logic [CORDW-1:0]  x1_q, y1_q;
    logic              hs1_q, vs1_q, de1_q, fr1_q;

    assign luma_sum = (BPC_IN+3)'(in_r) * (BPC_IN+3)'(LUMA_WR)
                    + (BPC_IN+3)'(in_g) * (BPC_IN+3)'(LUMA_WG)
                    + (BPC_IN+3)'(in_b) * (BPC_IN+3)'(LUMA_WB);
    assign luma = BPC_IN'(luma_sum >> LUMA_SHIFT);

    // Select the colour transform for the effective mode
    always_comb begin
        r1_d = in_r;
        g1_d = in_g;
        b1_d = in_b;
        case (mode_d)
            MODE_GREY: begin
                r1_d = luma;
                g1_d = luma;
                b1_d = luma;
            end
            MODE_BGR: begin
                r1_d = in_b;
                b1_d = in_r;
            end
            MODE_BLACK: begin
                r1_d = '0;
                g1_d = '0;
                b1_d = '0;
            end
            default: ;
        endcase
    end

    // Stage 1 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q  <= '0;
            y1_q  <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            de1_q <= 1'b0;
            fr1_q <= 1'b0;
            r1_q  <= '0;
            g1_q  <= '0;
            b1_q  <= '0;
        end else begin
            x1_q  <= in_x;
            y1_q  <= in_y;
            hs1_q <= in_hsync;
            vs1_q <= in_vsync;
            de1_q <= in_de;
            fr1_q <= in_frame;
            r1_q  <= r1_d;
            g1_q  <= g1_d;
            b1_q  <= b1_d;
        end
    end

`ifdef DISP_ADAPT_DITHER_EN
    // ---------------- frame counter for dither phase ----------------
    logic [1:0] fcnt_q, fcnt_d;
    logic [1:0] fc1_q;
    logic [1:0] bayer;
    assign fcnt_d = in_frame ? fcnt_q + 2'd1 : fcnt_q;

    // Count frames and carry the pixel's own count into stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 2'd0;
            fc1_q  <= 2'd0;
        end else begin
            fcnt_q <= fcnt_d;
            fc1_q  <= fcnt_q;
        end
    end

    assign bayer = bayer_value(x1_q[0] ^ fc1_q[0], y1_q[0] ^ fc1_q[1]);
`endif

    // ---------------- stage 2: width adapt and blanking ----------------
    logic [BPC_OUT-1:0] cr, cg, cb;
    logic [3*BPC_OUT-1:0] rgb2;
    logic [SW-1:0] s2_d, s2_q, s_out;

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_r (
        .c_i     (r1_q),
`ifdef DISP_ADAPT_DITHER_EN
        .bayer_i (bayer),
`endif
        .c_o     (cr)
    );

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_g (
        .c_i     (g1_q),
`ifdef DISP_ADAPT_DITHER_EN
        .bayer_i (bayer),
`endif
        .c_o     (cg)
    );

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_b (
        .c_i     (b1_q),
`ifdef DISP_ADAPT_DITHER_EN
        .bayer_i (bayer),
`endif
        .c_o     (cb)
    );

    assign rgb2 = de1_q ? {cr, cg, cb} : '0;
    assign s2_d = {x1_q, y1_q, hs1_q, vs1_q, de1_q, fr1_q, rgb2};

    // Stage 2 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s2_q <= '0;
        else        s2_q <= s2_d;
    end

    // ---------------- stages 3..PIPE: pure delay ----------------
    if (PIPE > 2) begin : g_delay
        logic [SW-1:0] dly_q [PIPE-2];

        // Shift the packed stage-2 word through the remaining stages
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE-2; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= s2_q;
                for (int i = 1; i < PIPE-2; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign s_out = dly_q[PIPE-3];
    end else begin : g_nodelay
        assign s_out = s2_q;
    end

    assign {out_x, out_y, out_hsync, out_vsync, out_de, out_frame,
            out_r, out_g, out_b} = s_out;

endmodule

`default_nettype wire

// File: tb/tb_disp_chan_adapt.sv
// ============================================================================
// Module      : tb_disp_chan_adapt
// Description : Directed self-checking bench for disp_chan_adapt. Three
//               instances share stimulus: defaults (5->8, PIPE 2), a
//               narrowing build (8->5) and a deep pipeline (PIPE 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_chan_adapt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [15:0] x, y;
    logic        hs, vs, de, fr;
    logic [4:0]  r, g, b;
    logic [7:0]  nr, ng, nb;

    logic [15:0] a_x, a_y, n_x, n_y, p_x, p_y;
    logic        a_hs, a_vs, a_de, a_fr;
    logic        n_hs, n_vs, n_de, n_fr;
    logic        p_hs, p_vs, p_de, p_fr;
    logic [7:0]  a_r, a_g, a_b, p_r, p_g, p_b;
    logic [4:0]  n_r, n_g, n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_chan_adapt u_a (
        .clk(clk), .rst_n(rst_n), .mode_in(mode),
        .in_x(x), .in_y(y), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_frame(fr),
        .in_r(r), .in_g(g), .in_b(b),
        .out_x(a_x), .out_y(a_y), .out_hsync(a_hs), .out_vsync(a_vs),
        .out_de(a_de), .out_frame(a_fr), .out_r(a_r), .out_g(a_g), .out_b(a_b)
    );

    disp_chan_adapt #(.BPC_IN(8), .BPC_OUT(5)) u_n (
        .clk(clk), .rst_n(rst_n), .mode_in(mode),
        .in_x(x), .in_y(y), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_frame(fr),
        .in_r(nr), .in_g(ng), .in_b(nb),
        .out_x(n_x), .out_y(n_y), .out_hsync(n_hs), .out_vsync(n_vs),
        .out_de(n_de), .out_frame(n_fr), .out_r(n_r), .out_g(n_g), .out_b(n_b)
    );

    disp_chan_adapt #(.PIPE(4)) u_p (
        .clk(clk), .rst_n(rst_n), .mode_in(mode),
        .in_x(x), .in_y(y), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_frame(fr),
        .in_r(r), .in_g(g), .in_b(b),
        .out_x(p_x), .out_y(p_y), .out_hsync(p_hs), .out_vsync(p_vs),
        .out_de(p_de), .out_frame(p_fr), .out_r(p_r), .out_g(p_g), .out_b(p_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; x = '0; y = '0;
        hs = 1'b0; vs = 1'b0; de = 1'b0; fr = 1'b0;
        r = '0; g = '0; b = '0; nr = '0; ng = '0; nb = '0;

        // reset state
        #3;
        chk("rst_a_r", 32'(a_r), 0);
        chk("rst_a_de", 32'(a_de), 0);
        chk("rst_a_x", 32'(a_x), 0);
        chk("rst_n_r", 32'(n_r), 0);
        chk("rst_p_r", 32'(p_r), 0);
        tick(); tick();
        @(negedge clk); rst_n = 1'b1;
        tick();

        // mode 0 widening 5->8 and narrowing 8->5 truncation
        x = 16'd100; y = 16'hFFFA; hs = 1'b1; vs = 1'b0; de = 1'b1;
        r = 5'd22; g = 5'd31; b = 5'd0; nr = 8'd181; ng = 8'd255; nb = 8'd7;
        tick();
        chk("lat1_a_de", 32'(a_de), 0);
        tick();
        chk("m0_r", 32'(a_r), 181);
        chk("m0_g", 32'(a_g), 255);
        chk("m0_b", 32'(a_b), 0);
        chk("m0_x", 32'(a_x), 100);
        chk("m0_y", 32'(a_y), 32'hFFFA);
        chk("m0_hs", 32'(a_hs), 1);
        chk("m0_vs", 32'(a_vs), 0);
        chk("m0_de", 32'(a_de), 1);
        chk("nar_181", 32'(n_r), 22);
        chk("nar_255", 32'(n_g), 31);
        chk("nar_7", 32'(n_b), 0);
        chk("p4_lat2_de", 32'(p_de), 0);
        tick(); tick();
        chk("p4_r", 32'(p_r), 181);
        chk("p4_x", 32'(p_x), 100);

        // mode request mid-frame is ignored until the frame-start pixel
        mode = 2'd1; r = 5'd31; g = 5'd0; b = 5'd0;
        tick(); tick();
        chk("hold_r", 32'(a_r), 255);
        chk("hold_g", 32'(a_g), 0);
        fr = 1'b1; tick(); fr = 1'b0; tick();
        chk("grey_r", 32'(a_r), 57);
        chk("grey_g", 32'(a_g), 57);
        chk("grey_b", 32'(a_b), 57);
        chk("grey_frame", 32'(a_fr), 1);
        mode = 2'd0; tick(); tick();
        chk("grey_kept_r", 32'(a_r), 57);
        chk("grey_kept_b", 32'(a_b), 57);
        chk("grey_frame_lo", 32'(a_fr), 0);
        r = 5'd31; g = 5'd31; b = 5'd31; tick(); tick();
        chk("grey_max_r", 32'(a_r), 255);
        chk("grey_max_g", 32'(a_g), 255);

        // BGR swap with blanking
        mode = 2'd2; fr = 1'b1; de = 1'b0; r = 5'd10; g = 5'd0; b = 5'd3;
        tick(); fr = 1'b0; de = 1'b1; tick();
        chk("blank_de", 32'(a_de), 0);
        chk("blank_r", 32'(a_r), 0);
        chk("blank_b", 32'(a_b), 0);
        tick();
        chk("bgr_r", 32'(a_r), 24);
        chk("bgr_g", 32'(a_g), 0);
        chk("bgr_b", 32'(a_b), 82);

        // black mode
        mode = 2'd3; fr = 1'b1; r = 5'd31; tick(); fr = 1'b0; tick();
        chk("black_de", 32'(a_de), 1);
        chk("black_r", 32'(a_r), 0);
        chk("black_b", 32'(a_b), 0);

        // narrowing across 2x2 positions on a fresh frame (frame count 3 -> 0)
        mode = 2'd0; x = 16'd0; y = 16'd0; nr = 8'd181; ng = 8'd181; nb = 8'd181;
        fr = 1'b1; tick(); fr = 1'b0;
        tick();
        chk("pos00", 32'(n_r), 22);
        x = 16'd1; tick(); tick();
`ifdef DISP_ADAPT_DITHER_EN
        chk("pos10", 32'(n_r), 23);
`else
        chk("pos10", 32'(n_r), 22);
`endif
        x = 16'd0; y = 16'd1; tick(); tick();
`ifdef DISP_ADAPT_DITHER_EN
        chk("pos01", 32'(n_r), 23);
`else
        chk("pos01", 32'(n_r), 22);
`endif
        x = 16'd1; nr = 8'd255; tick(); tick();
        chk("pos11_sat", 32'(n_r), 31);
        // next frame shifts the pattern phase
        x = 16'd0; y = 16'd0; nr = 8'd181;
        fr = 1'b1; tick(); fr = 1'b0; tick();
        chk("f0_pos00", 32'(n_r), 22);
        tick();
`ifdef DISP_ADAPT_DITHER_EN
        chk("f1_pos00", 32'(n_r), 23);
`else
        chk("f1_pos00", 32'(n_r), 22);
`endif

        // asynchronous reset mid-line on the deep pipeline
        mode = 2'd3; fr = 1'b1; tick(); fr = 1'b0;
        x = 16'd5; hs = 1'b1; de = 1'b1; r = 5'd22; g = 5'd31; b = 5'd0;
        repeat (5) tick();
        chk("pre_rst_p_de", 32'(p_de), 1);
        #2; rst_n = 1'b0; #1;
        chk("arst_p_de", 32'(p_de), 0);
        chk("arst_p_x", 32'(p_x), 0);
        chk("arst_p_hs", 32'(p_hs), 0);
        chk("arst_a_de", 32'(a_de), 0);
        @(negedge clk); rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_lat3", 32'(p_de), 0);
        tick();
        chk("post_rst_de", 32'(p_de), 1);
        chk("post_rst_mode0_r", 32'(p_r), 181);
        chk("post_rst_x", 32'(p_x), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
